// File: rtl/wfp_pkg.sv
// Shared types and constants for the waveform frame packer.
package wfp_pkg;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  localparam int         FRAME_HDR_LEN = 5;
  localparam logic [7:0] SYNC0_DEF     = 8'hA5;
  localparam logic [7:0] SYNC1_DEF     = 8'h5A;

  // sync(2) + seq + pulse(2) + samples(2 each) + checksum
  function automatic int frame_len(input int n);
    return 6 + 2 * n;
  endfunction

endpackage

// File: rtl/waveform_sample_ram.sv
// Window sample buffer: one write port, one synchronous read port (1-cycle latency).
module waveform_sample_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/waveform_frame_packer.sv
// Captures one triggered window into a local buffer and serializes it as a
// sync/seq/pulse/samples/checksum byte frame over a valid/ready byte port.
module waveform_frame_packer
  import wfp_pkg::*;
#(
  parameter int         N_SAMPLES = 32,
  parameter int         SAMPLE_W  = 14,
  parameter logic [7:0] SYNC0     = SYNC0_DEF,
  parameter logic [7:0] SYNC1     = SYNC1_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wave_valid,
  input  logic [SAMPLE_W-1:0] wave_sample,
  input  logic [SAMPLE_W-1:0] pulse_height,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int FRAME_LEN = frame_len(N_SAMPLES);
  localparam int IW        = $clog2(N_SAMPLES);
  localparam int BW        = $clog2(FRAME_LEN);
  localparam bit HDR_ODD   = (FRAME_HDR_LEN % 2) == 1;

  state_t              state, state_n;
  logic [IW-1:0]       idx;
  logic [BW-1:0]       bidx, bidx_n, off;
  logic [7:0]          seq, csum;
  logic [SAMPLE_W-1:0] ph_q, rdata;
  logic [15:0]         ph_ext, smp_ext;
  logic                wv_prev, skip;
  logic                start, cap_wr, last_smp, runt, drop_edge, fire, last_byte;
  logic                we;
  logic [IW-1:0]       waddr, raddr;

  // A window that was already counted as dropped must not restart capture mid-stream.
  assign start     = (state == IDLE) && wave_valid && !skip;
  assign cap_wr    = (state == CAPTURE) && wave_valid;
  assign last_smp  = cap_wr && (idx == IW'(N_SAMPLES - 1));
  assign runt      = (state == CAPTURE) && !wave_valid;
  assign drop_edge = (state == SEND) && wave_valid && !wv_prev;
  assign fire      = tx_valid && tx_ready;
  assign last_byte = (bidx == BW'(FRAME_LEN - 1));

  assign we    = start || cap_wr;
  assign waddr = start ? '0 : idx;

  // Address the sample for the byte index of the next cycle so RAM latency is hidden.
  always_comb begin
    bidx_n = bidx;
    if (state != SEND)  bidx_n = '0;
    else if (fire)      bidx_n = last_byte ? '0 : bidx + BW'(1);
  end
  assign off   = bidx_n - BW'(FRAME_HDR_LEN);
  assign raddr = IW'(off >> 1);

  waveform_sample_ram #(
    .DEPTH (N_SAMPLES),
    .WIDTH (SAMPLE_W),
    .AW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wave_sample),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CAPTURE;
      CAPTURE: begin
        if (last_smp)  state_n = SEND;
        else if (runt) state_n = IDLE;
      end
      SEND:    if (fire && last_byte) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    tx_valid = (state == SEND);
  end

  assign ph_ext  = 16'(ph_q);
  assign smp_ext = 16'(rdata);

  always_comb begin
    tx_data = 8'h00;
    if (state == SEND) begin
      if      (bidx == BW'(0)) tx_data = SYNC0;
      else if (bidx == BW'(1)) tx_data = SYNC1;
      else if (bidx == BW'(2)) tx_data = seq;
      else if (bidx == BW'(3)) tx_data = ph_ext[15:8];
      else if (bidx == BW'(4)) tx_data = ph_ext[7:0];
      else if (last_byte)      tx_data = csum;
      else if (bidx[0] == HDR_ODD) tx_data = smp_ext[15:8];
      else                     tx_data = smp_ext[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      bidx       <= '0;
      seq        <= 8'h00;
      csum       <= 8'h00;
      drop_count <= 8'h00;
      ph_q       <= '0;
      wv_prev    <= 1'b0;
      skip       <= 1'b0;
    end else begin
      bidx <= bidx_n;

      if (start)         idx <= IW'(1);
      else if (last_smp) idx <= '0;
      else if (cap_wr)   idx <= idx + IW'(1);
      else               idx <= '0;

      if (last_smp) ph_q <= pulse_height;

      // Checksum covers seq through the last sample byte, summed as bytes transfer.
      if (state != SEND)
        csum <= 8'h00;
      else if (fire && (bidx >= BW'(2)) && !last_byte)
        csum <= csum + tx_data;

      if (fire && last_byte) seq <= seq + 8'h01;

      if ((runt || drop_edge) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'h01;

      // Cleared on the last capture so a window held high straight into SEND counts as a new one.
      wv_prev <= last_smp ? 1'b0 : wave_valid;

      if (!wave_valid)    skip <= 1'b0;
      else if (drop_edge) skip <= 1'b1;
    end
  end

endmodule

// File: tb/tb_waveform_frame_packer.sv
// Directed bench for waveform_frame_packer: frame contents, backpressure, drops, seq wrap, reset.
module tb_waveform_frame_packer;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wave_valid;
  logic [13:0] wave_sample;
  logic [13:0] pulse_height;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int         stall_errs = 0;
  int         stalls     = 0;
  bit         stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;

  waveform_frame_packer dut (
    .clk          (clk),
    .reset        (reset),
    .wave_valid   (wave_valid),
    .wave_sample  (wave_sample),
    .pulse_height (pulse_height),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  // Byte collector and stall-stability watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && (!tx_valid || tx_data !== stall_data)) stall_errs++;
      stall_pend = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (tx_valid && !tx_ready) stalls++;
      if (tx_valid && tx_ready) q.push_back(tx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic drive_window(input int n, input int base, input logic [13:0] ph);
    for (int i = 0; i < n; i++) begin
      wave_valid   = 1'b1;
      wave_sample  = 14'(base + i);
      pulse_height = (i == N - 1) ? ph : 14'h0;
      tick();
    end
    wave_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input bit rnd);
    int n = 0;
    while (busy && n < 2000) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tx_ready = 1'b1;
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic build_exp(input logic [7:0] s, input int base, input logic [13:0] ph);
    logic [7:0]  sum;
    logic [13:0] v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(s);
    exp_q.push_back({2'b00, ph[13:8]});
    exp_q.push_back(ph[7:0]);
    for (int i = 0; i < N; i++) begin
      v = 14'(base + i);
      exp_q.push_back({2'b00, v[13:8]});
      exp_q.push_back(v[7:0]);
    end
    sum = 8'h00;
    for (int i = 2; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(sum);
  endtask

  task automatic check_frame(input string tag);
    int bad = -1;
    chk({tag, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      if (bad < 0 && q[i] !== exp_q[i]) bad = i;
    checks++;
    assert (bad < 0) else begin
      failures++;
      $error("FAIL %s byte %0d got=%h want=%h", tag, bad, q[bad], exp_q[bad]);
    end
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    wave_valid   = 1'b0;
    wave_sample  = '0;
    pulse_height = '0;
    tx_ready     = 1'b1;

    // Reset state
    #3;
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data",  {24'd0, tx_data}, 0);
    chk("rst_busy",     {31'd0, busy}, 0);
    chk("rst_drop",     {24'd0, drop_count}, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1. Ramp window, no backpressure
    q.delete();
    drive_window(N, 0, 14'h1234);
    chk("ramp_busy",     {31'd0, busy}, 1);
    chk("ramp_tx_valid", {31'd0, tx_valid}, 1);
    wait_idle("ramp_done", 1'b0);
    chk("ramp_b0",  {24'd0, q[0]},  32'hA5);
    chk("ramp_b1",  {24'd0, q[1]},  32'h5A);
    chk("ramp_seq", {24'd0, q[2]},  32'h00);
    chk("ramp_ph_msb", {24'd0, q[3]},  32'h12);
    chk("ramp_ph_lsb", {24'd0, q[4]},  32'h34);
    chk("ramp_s1_lsb", {24'd0, q[8]},  32'h01);
    chk("ramp_s31_lsb", {24'd0, q[68]}, 32'h1F);
    chk("ramp_csum", {24'd0, q[69]}, 32'h36);
    build_exp(8'h00, 0, 14'h1234);
    check_frame("ramp_frame");
    chk("idle_tx_valid", {31'd0, tx_valid}, 0);

    // 2. Same window under random backpressure
    q.delete();
    stall_errs = 0;
    stalls     = 0;
    drive_window(N, 0, 14'h1234);
    wait_idle("bp_done", 1'b1);
    build_exp(8'h01, 0, 14'h1234);
    check_frame("bp_frame");
    chk("bp_csum", {24'd0, q[69]}, 32'h37);
    chk("bp_stall_stable", stall_errs, 0);
    chk("bp_stalls_seen", {31'd0, stalls > 0}, 1);

    // 3. Runt window
    q.delete();
    drive_window(10, 0, 14'h0);
    chk("runt_busy_cap", {31'd0, busy}, 1);
    tick();
    chk("runt_busy", {31'd0, busy}, 0);
    chk("runt_drop", {24'd0, drop_count}, 1);
    tick(); tick();
    chk("runt_no_tx", q.size(), 0);

    // 4. Overlap: wave_valid held high for two windows' worth
    q.delete();
    drive_window(2 * N, 0, 14'h0ABC);
    wait_idle("ovl_done", 1'b0);
    build_exp(8'h02, 0, 14'h0ABC);
    check_frame("ovl_frame");
    chk("ovl_drop", {24'd0, drop_count}, 2);

    // 5. Sequence wrap with one forced overlap per window
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 257; i++) begin
      q.delete();
      drive_window(N + 1, i, 14'(i * 3));
      wait_idle("wrap_done", 1'b0);
      build_exp(8'(i), i, 14'(i * 3));
      check_frame("wrap_frame");
      if (i == 0)   chk("wrap_drop_first", {24'd0, drop_count}, 1);
      if (i == 254) chk("wrap_drop_255",   {24'd0, drop_count}, 255);
      if (i == 255) chk("wrap_seq_ff",     {24'd0, q[2]}, 32'hFF);
      if (i == 256) begin
        chk("wrap_seq_00",  {24'd0, q[2]}, 32'h00);
        chk("wrap_drop_sat", {24'd0, drop_count}, 255);
      end
    end

    // 6. Reset during a frame
    q.delete();
    drive_window(N, 100, 14'h0777);
    n = 0;
    while (q.size() < 20 && n < 200) begin
      tick();
      n++;
    end
    chk("mid_reached_20", {31'd0, q.size() >= 20}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_tx_valid", {31'd0, tx_valid}, 0);
    chk("mid_busy",     {31'd0, busy}, 0);
    chk("mid_drop",     {24'd0, drop_count}, 0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_quiet", {31'd0, tx_valid}, 0);
    q.delete();
    drive_window(N, 100, 14'h0777);
    wait_idle("post_rst_done", 1'b0);
    build_exp(8'h00, 100, 14'h0777);
    check_frame("post_rst_frame");
    chk("post_rst_seq", {24'd0, q[2]}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
